// File: rtl/tl_ul_pkg.sv
// Shared TileLink-UL definitions: opcodes, bus geometry and the A-channel field bundle.
// Also holds the helper that turns a Put request into its remaining beat count.
package tl_ul_pkg;

  localparam logic [2:0] PUT_FULL_DATA    = 3'd0;
  localparam logic [2:0] PUT_PARTIAL_DATA = 3'd1;
  localparam logic [2:0] GET              = 3'd4;
  localparam logic [2:0] ACCESS_ACK       = 3'd0;
  localparam logic [2:0] ACCESS_ACK_DATA  = 3'd1;

  localparam logic [2:0] BUS_BYTES_LG = 3'd2;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [2:0]  param;
    logic [2:0]  size;
    logic [31:0] address;
    logic [3:0]  mask;
    logic [31:0] data;
  } tl_a_fields_t;

  // Beats still owed after the first one; oversized Puts saturate the 4-bit counter.
  function automatic logic [3:0] burst_beats_left(input logic [2:0] opcode,
                                                  input logic [2:0] size,
                                                  input int         max_lgsize);
    logic [5:0] n;
    n = 6'd0;
    if ((opcode == PUT_FULL_DATA || opcode == PUT_PARTIAL_DATA) && size > BUS_BYTES_LG) begin
      n = (6'd1 << (size - BUS_BYTES_LG)) - 6'd1;
      if (int'(size) > max_lgsize || n > 6'd15) n = 6'd15;
    end
    return n[3:0];
  endfunction

endpackage

// File: rtl/tl_ul_a_arbiter_2to1.sv
// Two-requester TL-UL arbiter: round-robin A grant locked across Put bursts and
// stalled beats, requester tag in the top source bit, D routed back by that tag.
module tl_ul_a_arbiter_2to1 #(
  parameter int SRC_W      = 2,
  parameter int MAX_LGSIZE = 6
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              a0_valid,
  output logic              a0_ready,
  input  logic [2:0]        a0_opcode,
  input  logic [2:0]        a0_param,
  input  logic [2:0]        a0_size,
  input  logic [SRC_W-1:0]  a0_source,
  input  logic [31:0]       a0_address,
  input  logic [3:0]        a0_mask,
  input  logic [31:0]       a0_data,
  input  logic              a1_valid,
  output logic              a1_ready,
  input  logic [2:0]        a1_opcode,
  input  logic [2:0]        a1_param,
  input  logic [2:0]        a1_size,
  input  logic [SRC_W-1:0]  a1_source,
  input  logic [31:0]       a1_address,
  input  logic [3:0]        a1_mask,
  input  logic [31:0]       a1_data,
  output logic              a_valid,
  input  logic              a_ready,
  output logic [2:0]        a_opcode,
  output logic [2:0]        a_param,
  output logic [2:0]        a_size,
  output logic [SRC_W:0]    a_source,
  output logic [31:0]       a_address,
  output logic [3:0]        a_mask,
  output logic [31:0]       a_data,
  input  logic              d_valid,
  output logic              d_ready,
  input  logic [2:0]        d_opcode,
  input  logic [1:0]        d_param,
  input  logic [2:0]        d_size,
  input  logic [SRC_W:0]    d_source,
  input  logic              d_denied,
  input  logic              d_corrupt,
  input  logic [31:0]       d_data,
  output logic              d0_valid,
  input  logic              d0_ready,
  output logic [2:0]        d0_opcode,
  output logic [1:0]        d0_param,
  output logic [2:0]        d0_size,
  output logic [SRC_W-1:0]  d0_source,
  output logic              d0_denied,
  output logic              d0_corrupt,
  output logic [31:0]       d0_data,
  output logic              d1_valid,
  input  logic              d1_ready,
  output logic [2:0]        d1_opcode,
  output logic [1:0]        d1_param,
  output logic [2:0]        d1_size,
  output logic [SRC_W-1:0]  d1_source,
  output logic              d1_denied,
  output logic              d1_corrupt,
  output logic [31:0]       d1_data
);
  import tl_ul_pkg::*;

  logic       r_rr_last;
  logic       r_locked;
  logic       r_lock_owner;
  logic [3:0] r_beats_left;

  logic         w_grant;
  logic         w_a_fire;
  logic         w_d_port;
  logic [3:0]   w_first_left;
  tl_a_fields_t w_a0;
  tl_a_fields_t w_a1;
  tl_a_fields_t w_a_sel;

  logic       w_rr_last_nxt;
  logic       w_locked_nxt;
  logic       w_lock_owner_nxt;
  logic [3:0] w_beats_left_nxt;

  // With no contention the lone requester wins; on a tie the port not served last wins.
  function automatic logic rr_pick(input logic v0, input logic v1, input logic rr_last);
    if (v0 && !v1) return 1'b0;
    if (v1 && !v0) return 1'b1;
    return ~rr_last;
  endfunction

  assign w_grant = r_locked ? r_lock_owner : rr_pick(a0_valid, a1_valid, r_rr_last);

  assign w_a0 = '{opcode: a0_opcode, param: a0_param, size: a0_size,
                  address: a0_address, mask: a0_mask, data: a0_data};
  assign w_a1 = '{opcode: a1_opcode, param: a1_param, size: a1_size,
                  address: a1_address, mask: a1_mask, data: a1_data};
  assign w_a_sel = w_grant ? w_a1 : w_a0;

  assign a_opcode  = w_a_sel.opcode;
  assign a_param   = w_a_sel.param;
  assign a_size    = w_a_sel.size;
  assign a_address = w_a_sel.address;
  assign a_mask    = w_a_sel.mask;
  assign a_data    = w_a_sel.data;
  assign a_source  = {w_grant, (w_grant ? a1_source : a0_source)};

  // Handshakes are forced low while reset is held so nothing fires mid-reset.
  assign a_valid  = reset_n & (w_grant ? a1_valid : a0_valid);
  assign a0_ready = reset_n & ~w_grant & a_ready;
  assign a1_ready = reset_n &  w_grant & a_ready;
  assign w_a_fire = a_valid & a_ready;

  assign w_first_left = burst_beats_left(w_a_sel.opcode, w_a_sel.size, MAX_LGSIZE);

  always_comb begin
    w_rr_last_nxt    = r_rr_last;
    w_locked_nxt     = r_locked;
    w_lock_owner_nxt = r_lock_owner;
    w_beats_left_nxt = r_beats_left;
    if (w_a_fire) begin
      if (r_beats_left == 4'd0) begin
        w_beats_left_nxt = w_first_left;
        if (w_first_left != 4'd0) begin
          w_locked_nxt     = 1'b1;
          w_lock_owner_nxt = w_grant;
        end else begin
          w_locked_nxt  = 1'b0;
          w_rr_last_nxt = w_grant;
        end
      end else begin
        w_beats_left_nxt = r_beats_left - 4'd1;
        if (r_beats_left == 4'd1) begin
          w_locked_nxt  = 1'b0;
          w_rr_last_nxt = w_grant;
        end
      end
    end else if (a_valid) begin
      w_locked_nxt     = 1'b1;
      w_lock_owner_nxt = w_grant;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rr_last    <= 1'b1;
      r_locked     <= 1'b0;
      r_lock_owner <= 1'b0;
      r_beats_left <= 4'd0;
    end else begin
      r_rr_last    <= w_rr_last_nxt;
      r_locked     <= w_locked_nxt;
      r_lock_owner <= w_lock_owner_nxt;
      r_beats_left <= w_beats_left_nxt;
    end
  end

  // D channel: the tag bit picks the requester; payload is broadcast to both.
  assign w_d_port = d_source[SRC_W];
  assign d0_valid = reset_n & d_valid & ~w_d_port;
  assign d1_valid = reset_n & d_valid &  w_d_port;
  assign d_ready  = reset_n & (w_d_port ? d1_ready : d0_ready);

  assign d0_opcode  = d_opcode;
  assign d0_param   = d_param;
  assign d0_size    = d_size;
  assign d0_source  = d_source[SRC_W-1:0];
  assign d0_denied  = d_denied;
  assign d0_corrupt = d_corrupt;
  assign d0_data    = d_data;
  assign d1_opcode  = d_opcode;
  assign d1_param   = d_param;
  assign d1_size    = d_size;
  assign d1_source  = d_source[SRC_W-1:0];
  assign d1_denied  = d_denied;
  assign d1_corrupt = d_corrupt;
  assign d1_data    = d_data;

endmodule
